// File: rtl/counter_load_arbiter.sv
// Round-robin arbiter that shares one counter's load port among NUM_REQ requesters.
// Optional macro COUNTER_LOAD_ARBITER_STATS_EN adds saturating grant/reject counters.
//
// state | meaning
// IDLE  | waiting for any req; latches winner index and its data
// GRANT | one-cycle grant pulse with ack (legal) or err (illegal)
// LOAD  | one-cycle cnt_load with the latched value, counter enable held off
// COOL  | MIN_RUN-cycle cooldown before the next arbitration
module counter_load_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int MAX_COUNTER = 30,
  parameter int RANGE       = 2,
  parameter int MIN_RUN     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     run_en,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     ack,
  output logic                     err,
  output logic                     busy,
  output logic                     cnt_load,
  output logic [WIDTH-1:0]         cnt_data,
  output logic                     cnt_en
`ifdef COUNTER_LOAD_ARBITER_STATS_EN
  ,
  output logic [15:0]              grant_cnt,
  output logic [15:0]              reject_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT, LOAD, COOL} state_t;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MIN_RUN > 1) ? $clog2(MIN_RUN) : 1;
  localparam logic [CW-1:0] COOL_INIT = CW'((MIN_RUN > 0) ? MIN_RUN - 1 : 0);

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr, ptr_nxt, win, win_nxt, sel;
  logic               found, sel_legal;
  logic [WIDTH-1:0]   sel_data, data_q, data_nxt;
  logic [31:0]        sel_ext;
  logic [CW-1:0]      cool_cnt, cool_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               ack_nxt, err_nxt, load_nxt;

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr) + i) % NUM_REQ);
      end
    end
    sel_data  = req_data[int'(sel)*WIDTH +: WIDTH];
    sel_ext   = 32'(sel_data);
    sel_legal = ((sel_ext % 32'(RANGE)) == 32'd0) && (sel_ext < 32'(MAX_COUNTER));
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    win_nxt   = win;
    data_nxt  = data_q;
    cool_nxt  = cool_cnt;
    grant_nxt = '0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    load_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = GRANT;
          win_nxt        = sel;
          data_nxt       = sel_data;
          grant_nxt[sel] = 1'b1;
          ack_nxt        = sel_legal;
          err_nxt        = !sel_legal;
        end
      end
      GRANT: begin
        ptr_nxt = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        // ack was registered from the legality check, so it decides the path
        if (ack) begin
          state_nxt = LOAD;
          load_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (MIN_RUN > 0) begin
          state_nxt = COOL;
          cool_nxt  = COOL_INIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      COOL: begin
        if (cool_cnt == '0) state_nxt = IDLE;
        else                cool_nxt  = cool_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      data_q   <= '0;
      cool_cnt <= '0;
      grant    <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      cnt_load <= 1'b0;
      cnt_data <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      win      <= win_nxt;
      data_q   <= data_nxt;
      cool_cnt <= cool_nxt;
      grant    <= grant_nxt;
      ack      <= ack_nxt;
      err      <= err_nxt;
      busy     <= (state_nxt != IDLE);
      cnt_load <= load_nxt;
      if (load_nxt) cnt_data <= data_q;
    end
  end

  assign cnt_en = run_en & ~rst & (state != LOAD);

`ifdef COUNTER_LOAD_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt  <= '0;
      reject_cnt <= '0;
    end else begin
      if (ack && grant_cnt != 16'hFFFF)  grant_cnt  <= grant_cnt + 16'd1;
      if (err && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_load_arbiter.sv
// Scoreboard bench for counter_load_arbiter: expected grants are queued when requests
// are driven and checked, along with the following load/cooldown, when grants appear.
module tb_counter_load_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, run_en;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic           ack, err, busy, cnt_load, cnt_en;
  logic [W-1:0]   cnt_data;
`ifdef COUNTER_LOAD_ARBITER_STATS_EN
  logic [15:0]    grant_cnt, reject_cnt;
`endif

  counter_load_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .run_en(run_en),
    .grant(grant), .ack(ack), .err(err), .busy(busy), .cnt_load(cnt_load),
    .cnt_data(cnt_data), .cnt_en(cnt_en)
`ifdef COUNTER_LOAD_ARBITER_STATS_EN
    , .grant_cnt(grant_cnt), .reject_cnt(reject_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    logic         legal;
    logic [W-1:0] d;
  } exp_t;

  exp_t   sbq[$];
  exp_t   mon_e;
  int     total = 0, bad = 0;
  int     cyc = 0, n_grants = 0, phase = 0;
  int     exp_acks = 0, exp_errs = 0;
  logic         ph_legal;
  logic [W-1:0] ph_data;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic legal_f(int d);
    return (d % 2 == 0) && (d < 30);
  endfunction

  task automatic expect_grant(int idx, int d);
    exp_t e;
    e.g     = N'(1) << idx;
    e.legal = legal_f(d);
    e.d     = W'(d);
    sbq.push_back(e);
    if (e.legal) exp_acks++;
    else         exp_errs++;
  endtask

  task automatic wait_grant(string tag, int limit);
    int g0;
    g0 = n_grants;
    for (int k = 0; k < limit && n_grants == g0; k++) begin
      @(negedge clk);
      #1;
    end
    chk(tag, 32'(n_grants), 32'(g0 + 1));
  endtask

  task automatic single(int idx, int d);
    expect_grant(idx, d);
    req_data[idx*W +: W] = W'(d);
    req[idx] = 1'b1;
    wait_grant("grant_seen", 40);
    req[idx] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    exp_acks = 0;
    exp_errs = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Monitor: checks each grant against the scoreboard, then the load and cooldown after it.
  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
    end else begin
      if (phase == 1) begin
        if (ph_legal) begin
          chk("load_pulse", 32'(cnt_load), 32'd1);
          chk("load_data", 32'(cnt_data), 32'(ph_data));
          chk("load_en_off", 32'(cnt_en), 32'd0);
          chk("load_busy", 32'(busy), 32'd1);
          phase = 2;
        end else begin
          chk("rej_no_load", 32'(cnt_load), 32'd0);
          chk("rej_idle", 32'(busy), 32'd0);
          phase = 0;
        end
      end else if (phase >= 2 && phase <= 5) begin
        chk("cool_busy", 32'(busy), 32'd1);
        chk("cool_no_load", 32'(cnt_load), 32'd0);
        phase++;
      end else if (phase == 6) begin
        chk("cool_done", 32'(busy), 32'd0);
        phase = 0;
      end
      if (grant != '0) begin
        n_grants++;
        if (sbq.size() == 0) begin
          chk("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("grant", 32'(grant), 32'(mon_e.g));
          chk("ack", 32'(ack), 32'(mon_e.legal));
          chk("err", 32'(err), 32'(!mon_e.legal));
          ph_legal = mon_e.legal;
          ph_data  = mon_e.d;
          phase    = 1;
        end
      end
    end
  end

  initial begin
    int t[5];
    rst = 1'b1;
    run_en = 1'b1;
    req = '0;
    req_data = '0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load", 32'(cnt_load), 32'd0);
    chk("rst_data", 32'(cnt_data), 32'd0);
    chk("rst_en", 32'(cnt_en), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_en", 32'(cnt_en), 32'd1);

    single(1, 8);
    single(2, 15);
    single(2, 30);
    single(3, 28);
    chk("data_hold", 32'(cnt_data), 32'd28);
    run_en = 1'b0;
    #1;
    chk("en_off", 32'(cnt_en), 32'd0);
    run_en = 1'b1;
    single(0, 0);
    single(1, 29);

    do_reset();
    req_data = {8'd8, 8'd6, 8'd4, 8'd2};
    expect_grant(0, 2);
    expect_grant(1, 4);
    expect_grant(2, 6);
    expect_grant(3, 8);
    expect_grant(0, 2);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr_grant_seen", 20);
      t[k] = cyc;
    end
    req = '0;
    for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(t[k] - t[k-1]), 32'd7);
    repeat (10) @(negedge clk);

    req_data[0 +: W] = 8'd12;
    expect_grant(0, 12);
    req = 4'b0001;
    for (int k = 0; k < 20 && cnt_load !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_load_seen", 32'(cnt_load), 32'd1);
    rst = 1'b1;
    req = '0;
    #1;
    chk("arst_load", 32'(cnt_load), 32'd0);
    chk("arst_en", 32'(cnt_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    exp_acks = 0;
    exp_errs = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_data = {8'd8, 8'd6, 8'd4, 8'd2};
    expect_grant(0, 2);
    req = 4'b1111;
    wait_grant("post_rst_grant_seen", 20);
    req = '0;
    repeat (10) @(negedge clk);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
`ifdef COUNTER_LOAD_ARBITER_STATS_EN
    single(1, 4);
    single(2, 3);
    single(3, 10);
    single(0, 31);
    chk("grant_cnt", 32'(grant_cnt), 32'(exp_acks));
    chk("reject_cnt", 32'(reject_cnt), 32'(exp_errs));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
